// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: captures request lines into a pending register, masks them
// into an external priority encoder, and presents one ID at a time over valid/ack.
module irq_pending_ctrl #(
  parameter int N         = 8,
  parameter int IDW       = 3,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   irq_in,
  input  logic [N-1:0]   irq_mask,
  output logic [N-1:0]   enc_req,
  input  logic [IDW-1:0] enc_id,
  input  logic           enc_valid,
  output logic           irq_valid,
  output logic [IDW-1:0] irq_id,
  input  logic           irq_ack,
  output logic [N-1:0]   pending
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t       state;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic         ack_hit;
  logic         withdraw;

  generate
    if (EDGE_MODE) begin : g_edge
      logic [N-1:0] irq_prev;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_prev <= '0;
        else     irq_prev <= irq_in;
      end

      assign set_vec = irq_in & ~irq_prev;
    end else begin : g_level
      assign set_vec = irq_in;
    end
  endgenerate

  // Ack takes precedence over a simultaneous mask drop, so the bit is cleared.
  assign ack_hit  = (state == PRESENT) && irq_ack;
  assign withdraw = (state == PRESENT) && !irq_ack && !irq_mask[irq_id];

  always_comb begin
    clr_vec = '0;
    if (ack_hit) clr_vec[irq_id] = 1'b1;
  end

  assign enc_req = pending & irq_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= '0;
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      // Set is OR'd after the clear so a re-trigger on the ack edge survives.
      pending <= (pending & ~clr_vec) | set_vec;
      case (state)
        IDLE: begin
          if (enc_valid) begin
            irq_id    <= enc_id;
            irq_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (ack_hit || withdraw) begin
            irq_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          irq_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/irq_pending_ctrl.md
Name: irq_pending_ctrl

Overview:
- Interrupt front-end that sits directly upstream of the 8-to-3 priority encoder.
- Captures eight raw request lines into a pending register and applies a per-line enable mask.
- Drives the masked pending vector into the encoder and takes the encoded index and valid flag back.
- Presents one interrupt ID at a time to the consumer over a valid/ack handshake, clearing the serviced pending bit on acknowledge.

Parameters:
- N, 8, number of request lines. Fixed at 8 to match the encoder width.
- IDW, 3, ID width, equal to log2(N).
- EDGE_MODE, 1, 1 = rising-edge capture, 0 = level capture.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq_in  in  8  raw request lines, already synchronous to clk.
- irq_mask  in  8  per-line enable; 1 = line may be encoded.
- enc_req  out  8  pending & irq_mask, drives the encoder input vector.
- enc_id  in  3  encoder output index, combinational from enc_req.
- enc_valid  in  1  encoder valid; high when enc_req != 0.
- irq_valid  out  1  an interrupt ID is being presented.
- irq_id  out  3  presented ID; stable while irq_valid = 1.
- irq_ack  in  1  consumer accepts the presented ID.
- pending  out  8  raw pending register, for status readback.

Behaviour:
- Reset (async, rst = 1):
  - pending = 8'h00, irq_prev = 8'h00.
  - State = IDLE, irq_valid = 0, irq_id = 3'd0, hence enc_req = 8'h00.
  - Reset asserted mid-handshake drops irq_valid immediately and discards all pending bits.
- Capture:
  - EDGE_MODE = 1: set_vec = irq_in & ~irq_prev. irq_prev <= irq_in every cycle.
  - EDGE_MODE = 0: set_vec = irq_in.
  - pending <= (pending & ~clr_vec) | set_vec. Set wins over clear when both hit the same bit in the same cycle.
  - Masking never clears pending. A masked line stays pending and is encoded once unmasked.
- enc_req = pending & irq_mask, purely combinational from registers and irq_mask.
- FSM, two states:
  - IDLE: irq_valid = 0. If enc_valid = 1, latch irq_id <= enc_id and go to PRESENT. irq_ack is ignored in IDLE.
  - PRESENT: irq_valid = 1. irq_id is held even if a higher-priority line becomes pending.
  - PRESENT, irq_ack = 1: clr_vec = one-hot(irq_id), go to IDLE.
  - PRESENT, irq_mask[irq_id] = 0 with no ack: withdraw. Go to IDLE, pending bit kept, no clear.
  - PRESENT, ack and mask-drop in the same cycle: ack wins, the bit is cleared.
- Latency:
  - EDGE_MODE = 1: irq_in rises before edge k (mask set, FSM idle). pending bit set at edge k, irq_valid = 1 after edge k+1.
  - Ack sampled at edge m: irq_valid = 0 after edge m.
  - Next ID can be presented after edge m+1. irq_valid is therefore low for at least one cycle between IDs.
- Priority is defined solely by the encoder (bit 7 highest). This block performs no arbitration of its own.
- A line re-triggering while its own ID is presented (edge mode):
  - Re-set in the same cycle as ack: the bit stays pending and is re-presented later.
  - Earlier re-edge: absorbed, since the bit is already 1.
- Level mode: a line still high after ack re-sets pending on the ack edge and is presented again. The consumer must clear the source first.

Test Plan:
- Reset, irq_mask = 8'hFF, pulse irq_in = 8'h20 for one cycle -> pending = 8'h20 one edge later; irq_valid = 1 with irq_id = 5 one edge after that; ack -> pending = 8'h00, irq_valid = 0.
- irq_in = 8'h89 rising together -> IDs presented in order 7, 3, 0 across three acks, with irq_valid low for at least one cycle between each.
- Present ID 2, then raise irq_in[6] before ack -> irq_id stays 2 until ack; the next presentation is 6.
- irq_mask = 8'hEF, pulse irq_in[4] -> pending = 8'h10, irq_valid stays 0; set mask = 8'hFF -> irq_id = 4 presented. Then clear mask[4] while presenting -> irq_valid = 0 and pending = 8'h10 retained.
- Ack ID 1 in the same cycle as a new rising edge on irq_in[1] -> pending[1] remains 1 and ID 1 is re-presented.
- Assert rst asynchronously mid-PRESENT with pending = 8'h5A -> irq_valid, pending and enc_req go to 0 without waiting for a clock edge.
